// File: rtl/fp_branch_pkg.sv
// Shared types and constants for the branch redirect controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_branch_pkg;

    // Recovery sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } redir_state_t;

    // Sequential fetch stride for the not-taken fall-through address
    localparam int PC_INC = 4;

    // Default instruction address width
    localparam int DEF_PC_W = 8;

endpackage

// File: rtl/branch_redirect_controller_if.sv
// Resolution channel (EX -> controller) and redirect channel (controller -> fetch).
// Latency: n/a (wires only).
// Backpressure: res_ready gates resolutions; redir_ready gates redirects.
interface branch_redirect_controller_if #(
    parameter int PC_W = fp_branch_pkg::DEF_PC_W
);
    logic            res_valid;
    logic            res_ready;
    logic [PC_W-1:0] res_pc;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;
    logic            redir_ready;

    // Pipeline side: EX presents resolutions, fetch accepts redirects
    modport master (
        output res_valid, res_pc, res_taken, res_target, pred_taken, pred_target, redir_ready,
        input  res_ready, redir_valid, redir_pc
    );

    // Controller side
    modport slave (
        input  res_valid, res_pc, res_taken, res_target, pred_taken, pred_target, redir_ready,
        output res_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Latency: count updates one cycle after inc.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up unless already at the all-ones ceiling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_controller.sv
// Compares resolved branches with fetch's prediction and sequences flush + redirect on mispredict.
// Latency: accept N -> flush N+1..N+FLUSH_CYCLES, redir_valid from N+FLUSH_CYCLES+1.
// Backpressure: res_ready only in IDLE; REDIRECT holds until redir_ready.
module branch_redirect_controller
    import fp_branch_pkg::*;
#(
    parameter int PC_W         = DEF_PC_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    branch_redirect_controller_if.slave   bus,
    output logic                          flush_ifid,
    output logic                          flush_idex,
    output logic                          stall_ex,
    output logic [CNT_W-1:0]              branch_count,
    output logic [CNT_W-1:0]              mispredict_count
);

    redir_state_t    state, state_nxt;
    logic [3:0]      flush_cnt, flush_cnt_nxt;
    logic [PC_W-1:0] redir_pc_q, redir_pc_nxt;
    logic            accept;
    logic            mispredict;
    logic [PC_W-1:0] correct_pc;

    // Resolution compare; fall-through address wraps modulo 2^PC_W
    always_comb begin
        correct_pc = bus.res_taken ? bus.res_target : (bus.res_pc + PC_W'(PC_INC));
        mispredict = (bus.pred_taken != bus.res_taken) ||
                     (bus.res_taken && bus.pred_taken && (bus.pred_target != bus.res_target));
        accept     = bus.res_valid && (state == IDLE);
    end

    // Next-state, flush countdown and redirect address capture
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        redir_pc_nxt  = redir_pc_q;
        case (state)
            IDLE: begin
                if (accept && mispredict) begin
                    redir_pc_nxt  = correct_pc;
                    flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
                    state_nxt     = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = REDIRECT;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            REDIRECT: begin
                if (bus.redir_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and redirect address registers; reset discards any pending redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            flush_cnt  <= 4'd0;
            redir_pc_q <= '0;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            redir_pc_q <= redir_pc_nxt;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.res_ready   = (state == IDLE);
        bus.redir_valid = (state == REDIRECT);
        bus.redir_pc    = redir_pc_q;
        flush_ifid      = (state == FLUSH);
        flush_idex      = (state == FLUSH);
        stall_ex        = (state != IDLE);
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .count (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && mispredict),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Directed bench for branch_redirect_controller: main instance (CNT_W=16) and a CNT_W=4 saturation instance.
// Latency: n/a.
// Backpressure: redir_ready driven directly by the bench.
module tb_branch_redirect_controller;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    branch_redirect_controller_if #(.PC_W(8)) bus  ();
    branch_redirect_controller_if #(.PC_W(8)) bus4 ();

    logic        flush_ifid, flush_idex, stall_ex;
    logic [15:0] branch_count, mispredict_count;
    logic        flush_ifid4, flush_idex4, stall_ex4;
    logic [3:0]  branch_count4, mispredict_count4;

    branch_redirect_controller #(.PC_W(8), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus.slave),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .stall_ex         (stall_ex),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    branch_redirect_controller #(.PC_W(8), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus4.slave),
        .flush_ifid       (flush_ifid4),
        .flush_idex       (flush_idex4),
        .stall_ex         (stall_ex4),
        .branch_count     (branch_count4),
        .mispredict_count (mispredict_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] pc, input logic tk, input logic [7:0] tgt,
                           input logic ptk, input logic [7:0] ptgt);
        bus.res_valid   = 1'b1;
        bus.res_pc      = pc;
        bus.res_taken   = tk;
        bus.res_target  = tgt;
        bus.pred_taken  = ptk;
        bus.pred_target = ptgt;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_taken = 1'b0; bus.res_target = '0;
        bus.pred_taken = 1'b0; bus.pred_target = '0; bus.redir_ready = 1'b0;
        bus4.res_valid = 1'b0; bus4.res_pc = '0; bus4.res_taken = 1'b0; bus4.res_target = '0;
        bus4.pred_taken = 1'b0; bus4.pred_target = '0; bus4.redir_ready = 1'b0;
        #1;
        // Reset state
        chk("rst_res_ready",   32'(bus.res_ready), 32'd1);
        chk("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
        chk("rst_redir_pc",    32'(bus.redir_pc), 32'd0);
        chk("rst_flush",       32'({flush_ifid, flush_idex}), 32'd0);
        chk("rst_stall",       32'(stall_ex), 32'd0);
        chk("rst_bcnt",        32'(branch_count), 32'd0);
        chk("rst_mcnt",        32'(mispredict_count), 32'd0);
        @(negedge clk); reset = 1'b0;
        tick();

        // 1: correct not-taken
        present(8'h10, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        bus.res_valid = 1'b0;
        chk("t1_bcnt",      32'(branch_count), 32'd1);
        chk("t1_mcnt",      32'(mispredict_count), 32'd0);
        chk("t1_flush",     32'({flush_ifid, flush_idex}), 32'd0);
        chk("t1_res_ready", 32'(bus.res_ready), 32'd1);
        chk("t1_redir_vld", 32'(bus.redir_valid), 32'd0);

        // 2: direction mispredict; redir_ready held high through FLUSH is ignored
        present(8'h20, 1'b1, 8'h40, 1'b0, 8'h00);
        bus.redir_ready = 1'b1;
        tick();                                  // accept at N
        bus.res_valid = 1'b0;
        chk("t2_n1_flush",  32'({flush_ifid, flush_idex}), 32'd3);
        chk("t2_n1_stall",  32'(stall_ex), 32'd1);
        chk("t2_n1_rdy",    32'(bus.res_ready), 32'd0);
        chk("t2_n1_rvld",   32'(bus.redir_valid), 32'd0);
        tick();
        chk("t2_n2_flush",  32'({flush_ifid, flush_idex}), 32'd3);
        chk("t2_n2_rvld",   32'(bus.redir_valid), 32'd0);
        tick();
        chk("t2_n3_flush",  32'({flush_ifid, flush_idex}), 32'd0);
        chk("t2_n3_rvld",   32'(bus.redir_valid), 32'd1);
        chk("t2_n3_rpc",    32'(bus.redir_pc), 32'h40);
        chk("t2_mcnt",      32'(mispredict_count), 32'd1);
        tick();
        bus.redir_ready = 1'b0;
        chk("t2_idle_rdy",  32'(bus.res_ready), 32'd1);
        chk("t2_idle_rvld", 32'(bus.redir_valid), 32'd0);

        // 3: target mispredict, fetch stalls the redirect for 5 cycles
        present(8'h30, 1'b1, 8'h80, 1'b1, 8'h84);
        tick();
        bus.res_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_rvld", 32'(bus.redir_valid), 32'd1);
            chk("t3_hold_rpc",  32'(bus.redir_pc), 32'h80);
            chk("t3_hold_stall", 32'(stall_ex), 32'd1);
            tick();
        end
        bus.redir_ready = 1'b1;
        chk("t3_last_rvld", 32'(bus.redir_valid), 32'd1);
        tick();
        bus.redir_ready = 1'b0;
        chk("t3_idle_rdy",  32'(bus.res_ready), 32'd1);
        chk("t3_idle_stall", 32'(stall_ex), 32'd0);
        chk("t3_bcnt",      32'(branch_count), 32'd3);
        chk("t3_mcnt",      32'(mispredict_count), 32'd2);

        // 4: fall-through wrap, and a resolution offered mid-FLUSH is refused
        present(8'hFC, 1'b0, 8'h00, 1'b1, 8'h12);
        tick();
        present(8'h50, 1'b1, 8'h66, 1'b0, 8'h00);
        tick();
        bus.res_valid = 1'b0;
        chk("t4_bcnt",      32'(branch_count), 32'd4);
        chk("t4_mcnt",      32'(mispredict_count), 32'd3);
        tick();
        chk("t4_rvld",      32'(bus.redir_valid), 32'd1);
        chk("t4_rpc_wrap",  32'(bus.redir_pc), 32'h00);
        bus.redir_ready = 1'b1;
        tick();
        bus.redir_ready = 1'b0;
        chk("t4_bcnt_post", 32'(branch_count), 32'd4);

        // 5: reset asserted mid-cycle while in REDIRECT
        present(8'h30, 1'b1, 8'h55, 1'b0, 8'h00);
        tick();
        bus.res_valid = 1'b0;
        tick();
        tick();
        chk("t5_pre_rvld",  32'(bus.redir_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_rvld",  32'(bus.redir_valid), 32'd0);
        chk("t5_rst_stall", 32'(stall_ex), 32'd0);
        chk("t5_rst_flush", 32'({flush_ifid, flush_idex}), 32'd0);
        @(negedge clk); reset = 1'b0;
        tick();
        chk("t5_rdy",       32'(bus.res_ready), 32'd1);
        chk("t5_rvld",      32'(bus.redir_valid), 32'd0);
        chk("t5_bcnt",      32'(branch_count), 32'd0);
        chk("t5_mcnt",      32'(mispredict_count), 32'd0);

        // 6: saturation on the 4-bit instance
        bus4.res_valid = 1'b1; bus4.res_pc = 8'h10; bus4.res_taken = 1'b0; bus4.pred_taken = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("t6_cnt14", 32'(branch_count4), 32'd14);
            if (i == 15) chk("t6_cnt15", 32'(branch_count4), 32'd15);
        end
        bus4.res_valid = 1'b0;
        chk("t6_sat",       32'(branch_count4), 32'd15);
        chk("t6_mcnt",      32'(mispredict_count4), 32'd0);
        chk("t6_rdy",       32'(bus4.res_ready), 32'd1);
        tick();
        chk("t6_sat_hold",  32'(branch_count4), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
